// File: rtl/ahb_beat_engine.sv
// rtl/ahb_beat_engine.sv - AXI command to AHB-Lite single-beat engine
// Turns FWFT burst commands into NONSEQ single AHB transfers, one outstanding.
module ahb_beat_engine #(
  parameter int AXI_ID_WIDTH = 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  output logic                      cmd_r_en,
  input  logic                      cmd_fifo_empty,
  input  logic [AXI_ID_WIDTH+45:0]  cmd_data,
  output logic                      wdata_r_en,
  input  logic                      wdata_fifo_empty,
  input  logic [63:0]               axi_wdata,
  output logic [31:0]               haddr,
  output logic [1:0]                htrans,
  output logic                      hwrite,
  output logic [2:0]                hsize,
  output logic [2:0]                hburst,
  output logic [3:0]                hprot,
  output logic [63:0]               hwdata,
  input  logic [63:0]               hrdata,
  input  logic                      hready,
  input  logic                      hresp,
  output logic                      rdata_w_en,
  output logic [63:0]               rdata_w_data,
  input  logic                      rdata_fifo_full,
  output logic                      resp_w_en,
  output logic [1:0]                resp_w_data,
  input  logic                      resp_fifo_full,
  output logic                      id_resp_w_en,
  output logic [AXI_ID_WIDTH+1:0]   id_resp_w_data,
  input  logic                      id_resp_fifo_full
);
  localparam int W = AXI_ID_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_ADDR  = 2'd2;
  localparam logic [1:0] S_DATA  = 2'd3;

  logic [1:0]   state;
  logic         is_write_q;
  logic [1:0]   burst_q;
  logic [2:0]   size_q;
  logic [7:0]   len_q;
  logic [31:0]  cur_addr;
  logic [W-1:0] id_q;
  logic [7:0]   beat_cnt;
  logic         err_acc;

  logic [2:0]   cmd_size;
  logic [2:0]   cmd_eff_size;
  logic [31:0]  step;
  logic [31:0]  wrap_mask;
  logic         wrap_ok;
  logic [31:0]  next_addr;
  logic         can_issue;
  logic         last_beat;
  logic         beat_done;
  logic         push;

  assign cmd_size     = cmd_data[W+42:W+40];
  assign cmd_eff_size = (cmd_size > 3'd3) ? 3'd3 : cmd_size;
  assign step         = 32'd1 << size_q;
  assign wrap_mask    = ((({24'd0, len_q}) + 32'd1) << size_q) - 32'd1;
  assign wrap_ok      = (len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15);

  // Unsupported WRAP lengths fall back to INCR behaviour.
  always_comb begin
    next_addr = cur_addr + step;
    if (burst_q == 2'b00)
      next_addr = cur_addr;
    else if (burst_q == 2'b10 && wrap_ok)
      next_addr = (cur_addr & ~wrap_mask) | ((cur_addr + step) & wrap_mask);
  end

  assign can_issue = !rdata_fifo_full && !resp_fifo_full && !id_resp_fifo_full &&
                     (!is_write_q || !wdata_fifo_empty);
  assign last_beat = (beat_cnt == len_q);
  assign beat_done = (state == S_DATA) && hready;

  assign cmd_r_en   = aresetn && (state == S_IDLE) && !cmd_fifo_empty;
  assign wdata_r_en = aresetn && (state == S_ISSUE) && can_issue && is_write_q;

  // Writes report once per burst; reads report every beat.
  assign push           = aresetn && beat_done && (!is_write_q || last_beat);
  assign rdata_w_en     = push;
  assign resp_w_en      = push;
  assign id_resp_w_en   = push;
  assign rdata_w_data   = is_write_q ? 64'd0 : hrdata;
  assign resp_w_data    = ((is_write_q && err_acc) || hresp) ? 2'b10 : 2'b00;
  assign id_resp_w_data = {is_write_q, last_beat, id_q};

  assign hburst = 3'b000;
  assign hprot  = 4'b0011;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      is_write_q <= 1'b0;
      burst_q    <= 2'b00;
      size_q     <= 3'd0;
      len_q      <= 8'd0;
      cur_addr   <= 32'd0;
      id_q       <= '0;
      beat_cnt   <= 8'd0;
      err_acc    <= 1'b0;
      haddr      <= 32'd0;
      htrans     <= 2'b00;
      hwrite     <= 1'b0;
      hsize      <= 3'd0;
      hwdata     <= 64'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!cmd_fifo_empty) begin
            is_write_q <= cmd_data[W+45];
            burst_q    <= cmd_data[W+44:W+43];
            size_q     <= cmd_eff_size;
            len_q      <= cmd_data[W+39:W+32];
            cur_addr   <= cmd_data[W+31:W];
            id_q       <= cmd_data[W-1:0];
            beat_cnt   <= 8'd0;
            err_acc    <= 1'b0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (can_issue) begin
            haddr  <= cur_addr;
            htrans <= 2'b10;
            hwrite <= is_write_q;
            hsize  <= size_q;
            if (is_write_q)
              hwdata <= axi_wdata;
            state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (hready) begin
            htrans <= 2'b00;
            state  <= S_DATA;
          end
        end
        default: begin
          // An error's first cycle (hready low) is ignored; the beat ends on hready.
          if (hready) begin
            err_acc <= err_acc | hresp;
            if (last_beat) begin
              state <= S_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
              cur_addr <= next_addr;
              state    <= S_ISSUE;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_beat_engine.sv
// tb/tb_ahb_beat_engine.sv - self-checking bench for ahb_beat_engine
// Directed and random commands against an AHB slave model and expected-transfer lists.
module tb_ahb_beat_engine;
  localparam int W = 8;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          cmd_r_en;
  logic          cmd_fifo_empty;
  logic [W+45:0] cmd_data;
  logic          wdata_r_en;
  logic          wdata_fifo_empty;
  logic [63:0]   axi_wdata;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [3:0]    hprot;
  logic [63:0]   hwdata;
  logic [63:0]   hrdata;
  logic          hready;
  logic          hresp;
  logic          rdata_w_en;
  logic [63:0]   rdata_w_data;
  logic          rdata_fifo_full;
  logic          resp_w_en;
  logic [1:0]    resp_w_data;
  logic          resp_fifo_full;
  logic          id_resp_w_en;
  logic [W+1:0]  id_resp_w_data;
  logic          id_resp_fifo_full;

  ahb_beat_engine #(.AXI_ID_WIDTH(W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_r_en(cmd_r_en), .cmd_fifo_empty(cmd_fifo_empty), .cmd_data(cmd_data),
    .wdata_r_en(wdata_r_en), .wdata_fifo_empty(wdata_fifo_empty), .axi_wdata(axi_wdata),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .rdata_w_en(rdata_w_en), .rdata_w_data(rdata_w_data), .rdata_fifo_full(rdata_fifo_full),
    .resp_w_en(resp_w_en), .resp_w_data(resp_w_data), .resp_fifo_full(resp_fifo_full),
    .id_resp_w_en(id_resp_w_en), .id_resp_w_data(id_resp_w_data),
    .id_resp_fifo_full(id_resp_fifo_full)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pop_cyc = 0;
  int en_split = 0;
  bit rand_ready = 1'b0;

  logic [W+45:0] cq[$];
  logic [63:0]   wq[$];
  logic [63:0]   wd_pend[$];
  logic [63:0]   rd_plan[$];
  bit            err_plan[$];
  int            wait_plan[$];
  logic [63:0]   wd_plan[$];

  logic [31:0] obs_addr[$];
  logic [63:0] obs_hw[$];
  logic        obs_write[$];
  logic [2:0]  obs_size[$];
  logic [63:0] obs_wpop[$];
  logic [63:0] obs_rd[$];
  logic [1:0]  obs_resp[$];
  logic [W+1:0] obs_idr[$];
  int          obs_pcyc[$];

  logic [31:0] exp_addr[$];
  logic [63:0] exp_wd[$];
  logic [63:0] exp_rd[$];
  logic [1:0]  exp_resp[$];
  logic [W+1:0] exp_idr[$];
  bit          cur_wr;
  int          cur_n;
  logic [2:0]  cur_eff;

  bit cmd_pop_flag = 0, wd_pop_flag = 0, start_flag = 0, done_flag = 0;
  bit in_data = 0;
  bit cur_err = 0;
  bit err_stage = 0;
  int cur_wait = 0;
  logic [63:0] cur_rd = '0;

  // Monitor: samples mid-cycle, requests FIFO/slave updates for after the next edge.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (cmd_r_en) begin cmd_pop_flag = 1; pop_cyc = cyc; end
      if (wdata_r_en) begin wd_pop_flag = 1; obs_wpop.push_back(axi_wdata); end
      if (htrans == 2'b10 && hready) begin
        obs_addr.push_back(haddr); obs_hw.push_back(hwdata);
        obs_write.push_back(hwrite); obs_size.push_back(hsize);
        start_flag = 1;
      end
      if (in_data && hready) done_flag = 1;
      if (rdata_w_en !== resp_w_en || rdata_w_en !== id_resp_w_en) en_split++;
      if (rdata_w_en) begin
        obs_rd.push_back(rdata_w_data); obs_resp.push_back(resp_w_data);
        obs_idr.push_back(id_resp_w_data); obs_pcyc.push_back(cyc);
      end
    end
  end

  // FIFO sources and AHB slave model, updated just after each rising edge.
  always @(posedge aclk) begin
    cyc++;
    #1;
    if (!aresetn) begin
      in_data = 0; cmd_pop_flag = 0; wd_pop_flag = 0; start_flag = 0; done_flag = 0;
    end else begin
      if (cmd_pop_flag && cq.size() > 0) void'(cq.pop_front());
      if (wd_pop_flag && wq.size() > 0) void'(wq.pop_front());
      if (done_flag) in_data = 0;
      if (start_flag) begin
        in_data   = 1;
        err_stage = 0;
        cur_wait  = (wait_plan.size() > 0) ? wait_plan.pop_front() : 0;
        cur_err   = (err_plan.size() > 0) ? err_plan.pop_front() : 1'b0;
        cur_rd    = (rd_plan.size() > 0) ? rd_plan.pop_front() : 64'd0;
      end
      cmd_pop_flag = 0; wd_pop_flag = 0; start_flag = 0; done_flag = 0;
    end
    if (wd_pend.size() > 0 && (!rand_ready || $urandom_range(0, 1) == 1))
      wq.push_back(wd_pend.pop_front());
    cmd_fifo_empty   = (cq.size() == 0);
    cmd_data         = (cq.size() > 0) ? cq[0] : '0;
    wdata_fifo_empty = (wq.size() == 0);
    axi_wdata        = (wq.size() > 0) ? wq[0] : 64'd0;
    if (in_data) begin
      hrdata = cur_rd;
      if (cur_wait > 0) begin hready = 0; hresp = 0; cur_wait--; end
      else if (cur_err && !err_stage) begin hready = 0; hresp = 1; err_stage = 1; end
      else begin hready = 1; hresp = cur_err; end
    end else begin
      hresp  = 0;
      hready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      hrdata = {$urandom, $urandom};
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input bit wr, input logic [1:0] bu, input logic [2:0] sz,
                           input logic [7:0] ln, input logic [31:0] ad, input logic [7:0] id);
    logic [31:0] step, wb, base, a;
    bit wrap, any_err;
    cur_n   = int'(ln) + 1;
    cur_wr  = wr;
    cur_eff = (sz > 3'd3) ? 3'd3 : sz;
    step    = 32'd1 << cur_eff;
    wb      = cur_n * step;
    wrap    = (bu == 2'b10) && (ln == 8'd1 || ln == 8'd3 || ln == 8'd7 || ln == 8'd15);
    base    = ad & ~(wb - 32'd1);
    while (rd_plan.size() < cur_n) rd_plan.push_back({$urandom, $urandom});
    while (err_plan.size() < cur_n) err_plan.push_back(rand_ready && $urandom_range(0, 5) == 0);
    while (wait_plan.size() < cur_n) wait_plan.push_back(rand_ready ? $urandom_range(0, 2) : 0);
    if (wr) while (wd_plan.size() < cur_n) wd_plan.push_back({$urandom, $urandom});
    obs_addr.delete(); obs_hw.delete(); obs_write.delete(); obs_size.delete();
    obs_wpop.delete(); obs_rd.delete(); obs_resp.delete(); obs_idr.delete(); obs_pcyc.delete();
    exp_addr.delete(); exp_rd.delete(); exp_resp.delete(); exp_idr.delete(); exp_wd.delete();
    any_err = 0;
    for (int i = 0; i < cur_n; i++) begin
      if (bu == 2'b00) a = ad;
      else if (wrap) a = base + ((ad - base + i * step) % wb);
      else a = ad + i * step;
      exp_addr.push_back(a);
      any_err |= err_plan[i];
      if (!wr) begin
        exp_rd.push_back(rd_plan[i]);
        exp_resp.push_back(err_plan[i] ? 2'b10 : 2'b00);
        exp_idr.push_back({1'b0, i == cur_n - 1, id});
      end
    end
    if (wr) begin
      exp_rd.push_back(64'd0);
      exp_resp.push_back(any_err ? 2'b10 : 2'b00);
      exp_idr.push_back({1'b1, 1'b1, id});
      exp_wd = wd_plan;
      foreach (wd_plan[i]) wd_pend.push_back(wd_plan[i]);
      wd_plan.delete();
    end
    cq.push_back({wr, bu, sz, ln, ad, id});
  endtask

  task automatic finish_cmd();
    bit timed_out = 1;
    for (int c = 0; c < 60 * cur_n + 100; c++) begin
      @(posedge aclk); #2;
      if (obs_addr.size() >= cur_n && obs_rd.size() >= exp_rd.size()) begin
        timed_out = 0;
        break;
      end
    end
    repeat (4) @(posedge aclk);
    #2;
    check("timeout", timed_out, 0);
    check("addr_count", obs_addr.size(), cur_n);
    for (int i = 0; i < cur_n && i < obs_addr.size(); i++) begin
      check("haddr", obs_addr[i], exp_addr[i]);
      check("hwrite", obs_write[i], cur_wr);
      check("hsize", obs_size[i], cur_eff);
      if (cur_wr) check("hwdata", obs_hw[i], exp_wd[i]);
    end
    check("push_count", obs_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++) begin
      check("rdata", obs_rd[i], exp_rd[i]);
      check("resp", obs_resp[i], exp_resp[i]);
      check("id_resp", obs_idr[i], exp_idr[i]);
    end
    check("wdata_pops", obs_wpop.size(), cur_wr ? cur_n : 0);
    for (int i = 0; i < obs_wpop.size() && i < exp_wd.size(); i++)
      check("wdata_pop_val", obs_wpop[i], exp_wd[i]);
    check("en_together", en_split, 0);
  endtask

  initial begin
    bit ok;
    logic [7:0] ln;
    aresetn = 0;
    rdata_fifo_full = 0; resp_fifo_full = 0; id_resp_fifo_full = 0;
    repeat (3) @(posedge aclk);
    #2;
    check("reset_outputs", {haddr, htrans, hwrite, hsize, cmd_r_en, wdata_r_en, rdata_w_en,
                            resp_w_en, id_resp_w_en}, 0);
    check("reset_hwdata", hwdata, 0);
    check("hburst", hburst, 3'b000);
    check("hprot", hprot, 4'b0011);
    @(negedge aclk);
    aresetn = 1;

    // Single read with fixed data, then latency from pop to push.
    rd_plan.push_back(64'hDEADBEEF00000001);
    start_cmd(0, 2'b01, 3'd3, 8'd0, 32'h1000, 8'h05);
    finish_cmd();
    if (obs_pcyc.size() > 0) check("latency", obs_pcyc[0] - pop_cyc, 3);
    else check("latency_push", 0, 1);

    start_cmd(0, 2'b01, 3'd2, 8'd3, 32'h2004, 8'h11);
    finish_cmd();
    start_cmd(0, 2'b10, 3'd3, 8'd3, 32'h3018, 8'h22);
    finish_cmd();

    // Write with a two-cycle error response on beat 0.
    wd_plan.push_back(64'hA); wd_plan.push_back(64'hB);
    err_plan.push_back(1'b1); err_plan.push_back(1'b0);
    start_cmd(1, 2'b01, 3'd3, 8'd1, 32'h4000, 8'h3C);
    finish_cmd();

    // Back-pressure from the read-data FIFO mid-burst.
    start_cmd(0, 2'b01, 3'd3, 8'd3, 32'h4800, 8'h44);
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge aclk); #2;
      if (obs_rd.size() >= 1) begin ok = 1; break; end
    end
    check("first_push_seen", ok, 1);
    rdata_fifo_full = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk); #1;
      check("stall", {htrans, cmd_r_en, wdata_r_en, rdata_w_en}, 0);
      @(posedge aclk); #2;
    end
    rdata_fifo_full = 0;
    @(negedge aclk); #1;
    check("stall_last", htrans, 2'b00);
    @(posedge aclk); #2;
    check("resume", htrans, 2'b10);
    finish_cmd();

    // Reset asserted during the data phase of beat 2.
    start_cmd(0, 2'b01, 3'd3, 8'd3, 32'h5000, 8'h55);
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge aclk); #2;
      if (obs_addr.size() >= 3) begin ok = 1; break; end
    end
    check("beat2_addr_seen", ok, 1);
    aresetn = 0;
    #1;
    check("mid_reset_outputs", {haddr, htrans, hwrite, hsize, cmd_r_en, wdata_r_en, rdata_w_en,
                                resp_w_en, id_resp_w_en}, 0);
    check("mid_reset_hwdata", hwdata, 0);
    rd_plan.delete(); err_plan.delete(); wait_plan.delete(); wd_plan.delete();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("no_push_on_reset", obs_rd.size(), 2);
    aresetn = 1;
    start_cmd(0, 2'b01, 3'd3, 8'd0, 32'h6000, 8'h66);
    finish_cmd();

    rand_ready = 1;
    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(0, 4))
        0: ln = 8'd1;
        1: ln = 8'd3;
        2: ln = 8'd7;
        3: ln = 8'd15;
        default: ln = 8'($urandom_range(0, 20));
      endcase
      start_cmd($urandom_range(0, 1), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                ln, $urandom, 8'($urandom));
      finish_cmd();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
